// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, segment codes and digit decoder for countdown_timer
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_0     = 7'h3f;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5b;
   localparam logic [6:0] SEG_3     = 7'h4f;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6d;
   localparam logic [6:0] SEG_6     = 7'h7d;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7f;
   localparam logic [6:0] SEG_9     = 7'h6f;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Non-BCD codes fall through to a dark digit rather than a garbage pattern
   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, level debouncer and press-pulse generator for one button
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] count;

   // Two-flop synchronizer for the asynchronous pushbutton
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         level <= 1'b0;
      end else if (sync_2 == level) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
         level <= ~level;
      end else begin
         count <= count + CW'(1);
      end
   end

   // Registered one-cycle pulse on the debounced rising edge; releases are ignored
   always_ff @(posedge clk) begin
      if (!rst) begin
         level_d   <= 1'b0;
         key_press <= 1'b0;
      end else begin
         level_d   <= level;
         key_press <= level & ~level_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - two-digit BCD countdown timer with alarm; COUNTDOWN_BLINK_DONE_EN blinks the display in DONE
module countdown_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV        = 12000000,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int START_VAL       = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_load,
   output logic [8:0] seg_led_1,
   output logic [8:0] seg_led_2,
   output logic       running,
   output logic       alarm
);

   localparam logic [3:0] START_TENS = 4'(START_VAL / 10);
   localparam logic [3:0] START_ONES = 4'(START_VAL % 10);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   state_t        state;
   state_t        state_next;
   logic          start_press;
   logic          load_press;
   logic          running_next;
   logic          alarm_next;
   logic          enter_run;
   logic          reload;
   logic          tick;
   logic          at_one;
   logic          at_zero;
   logic          show_blank;
   logic [TW-1:0] tick_cnt;
   logic [3:0]    tens;
   logic [3:0]    ones;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (btn_start),
      .key_press (start_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (btn_load),
      .key_press (load_press)
   );

   assign at_one  = (tens == 4'd0) && (ones == 4'd1);
   assign at_zero = (tens == 4'd0) && (ones == 4'd0);
   assign tick    = (state == RUN) && (tick_cnt == TICK_LAST);

   // State register; running/alarm are decoded from the next state so they track it exactly
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         running <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         state   <= state_next;
         running <= running_next;
         alarm   <= alarm_next;
      end
   end

   // Next state; load overrides everything, reaching 00 overrides a pause request
   always_comb begin
      state_next = state;
      if (load_press) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_press) state_next = RUN;
            RUN: begin
               if (tick && at_one)   state_next = DONE;
               else if (start_press) state_next = PAUSE;
            end
            PAUSE:   if (start_press) state_next = RUN;
            DONE:    if (start_press) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs and datapath controls derived from the transition
   always_comb begin
      running_next = (state_next == RUN);
      alarm_next   = (state_next == DONE);
      enter_run    = (state_next == RUN) && (state != RUN);
      reload       = load_press || ((state == DONE) && (state_next == IDLE));
   end

   // Tick divider: runs only in RUN, restarts from zero on each entry, holds while paused
   always_ff @(posedge clk) begin
      if (!rst || load_press || enter_run) begin
         tick_cnt <= '0;
      end else if (state == RUN) begin
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      end
   end

   // BCD down-count, saturating at 00
   always_ff @(posedge clk) begin
      if (!rst || reload) begin
         tens <= START_TENS;
         ones <= START_ONES;
      end else if (tick && !at_zero) begin
         if (ones != 4'd0) begin
            ones <= ones - 4'd1;
         end else begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
         end
      end
   end

`ifdef COUNTDOWN_BLINK_DONE_EN
   localparam int HALF = TICK_DIV / 2;
   localparam int HW = $clog2(HALF + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

   logic [HW-1:0] half_cnt;
   logic          blank;

   // Half-period blink timer, alive only in DONE so each DONE entry starts on 00
   always_ff @(posedge clk) begin
      if (!rst || state != DONE) begin
         half_cnt <= '0;
         blank    <= 1'b0;
      end else if (half_cnt == HALF_LAST) begin
         half_cnt <= '0;
         blank    <= ~blank;
      end else begin
         half_cnt <= half_cnt + HW'(1);
      end
   end

   assign show_blank = (state == DONE) && blank;
`else
   assign show_blank = 1'b0;
`endif

   // Registered segment drive, one cycle behind the digit registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_led_1 <= {2'b00, digit_to_seg(START_ONES)};
         seg_led_2 <= {2'b00, digit_to_seg(START_TENS)};
      end else if (show_blank) begin
         seg_led_1 <= 9'h000;
         seg_led_2 <= 9'h000;
      end else begin
         seg_led_1 <= {2'b00, digit_to_seg(ones)};
         seg_led_2 <= {2'b00, digit_to_seg(tens)};
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start;
   logic       btn_load;
   logic [8:0] seg_led_1;
   logic [8:0] seg_led_2;
   logic       running;
   logic       alarm;
   logic [8:0] seg20_1;
   logic [8:0] seg20_2;
   logic       running20;
   logic       alarm20;

   int checks = 0;
   int passes = 0;

   localparam logic [8:0] S0 = 9'h03f;
   localparam logic [8:0] S1 = 9'h006;
   localparam logic [8:0] S2 = 9'h05b;
   localparam logic [8:0] S3 = 9'h04f;
   localparam logic [8:0] S9 = 9'h06f;
`ifdef COUNTDOWN_BLINK_DONE_EN
   localparam logic [8:0] S_OFF = 9'h000;
`else
   localparam logic [8:0] S_OFF = 9'h03f;
`endif

   countdown_timer #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .START_VAL(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_load  (btn_load),
      .seg_led_1 (seg_led_1),
      .seg_led_2 (seg_led_2),
      .running   (running),
      .alarm     (alarm)
   );

   countdown_timer #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .START_VAL(20)) u_dut20 (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_load  (btn_load),
      .seg_led_1 (seg20_1),
      .seg_led_2 (seg20_2),
      .running   (running20),
      .alarm     (alarm20)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b0;
      btn_start = 1'b0;
      btn_load = 1'b0;
      step(3);
      chk("reset_seg2", seg_led_2, S0);
      chk("reset_seg1", seg_led_1, S3);
      chk("reset_running", {8'd0, running}, 9'd0);
      chk("reset_alarm", {8'd0, alarm}, 9'd0);
      chk("reset20_seg2", seg20_2, S2);
      chk("reset20_seg1", seg20_1, S0);
      chk("reset20_alarm", {8'd0, alarm20}, 9'd0);
      rst = 1'b1;
      step(2);

      // full countdown 03 -> 00
      btn_start = 1'b1;
      step(7);  chk("start_pre_pulse_running", {8'd0, running}, 9'd0);
      step(1);  chk("start_running", {8'd0, running}, 9'd1);
                chk("start20_running", {8'd0, running20}, 9'd1);
      btn_start = 1'b0;
      step(10); chk("before_tick1_seg1", seg_led_1, S3);
                chk("before_tick1_20_seg1", seg20_1, S0);
      step(1);  chk("tick1_seg1", seg_led_1, S2);
                chk("tick1_seg2", seg_led_2, S0);
                chk("tick1_20_seg2", seg20_2, S1);
                chk("tick1_20_seg1", seg20_1, S9);
      step(9);  chk("before_tick2_seg1", seg_led_1, S2);
      step(1);  chk("tick2_seg1", seg_led_1, S1);
      step(8);  chk("before_done_alarm", {8'd0, alarm}, 9'd0);
      step(1);  chk("done_alarm", {8'd0, alarm}, 9'd1);
                chk("done_running", {8'd0, running}, 9'd0);
      step(1);  chk("done_seg1", seg_led_1, S0);
                chk("done_seg2", seg_led_2, S0);
      step(4);  chk("done_seg1_hold", seg_led_1, S0);
      step(1);  chk("done_blink_phase1_seg1", seg_led_1, S_OFF);
                chk("done_blink_phase1_seg2", seg_led_2, S_OFF);
      step(4);  chk("done_blink_phase1_end", seg_led_1, S_OFF);
      step(1);  chk("done_blink_phase2", seg_led_1, S0);
                chk("done_alarm_steady", {8'd0, alarm}, 9'd1);

      // start in DONE returns to IDLE with the preset
      btn_start = 1'b1;
      step(7);  chk("done_exit_pre_alarm", {8'd0, alarm}, 9'd1);
      step(1);  chk("done_exit_alarm", {8'd0, alarm}, 9'd0);
                chk("done_exit_running", {8'd0, running}, 9'd0);
      btn_start = 1'b0;
      step(1);  chk("done_exit_seg1", seg_led_1, S3);
                chk("done_exit_seg2", seg_led_2, S0);
      step(10);

      // pause at 02, then resume
      btn_start = 1'b1;
      step(8);  chk("pause_test_running", {8'd0, running}, 9'd1);
      btn_start = 1'b0;
      step(7);
      btn_start = 1'b1;
      step(4);  chk("pause_test_seg1_02", seg_led_1, S2);
      step(3);  chk("pause_pre_pulse_running", {8'd0, running}, 9'd1);
      step(1);  chk("paused_running", {8'd0, running}, 9'd0);
      btn_start = 1'b0;
      step(17); chk("paused_seg1_frozen", seg_led_1, S2);
                chk("paused_running_low", {8'd0, running}, 9'd0);
      btn_start = 1'b1;
      step(7);  chk("resume_pre_running", {8'd0, running}, 9'd0);
      step(1);  chk("resume_running", {8'd0, running}, 9'd1);
      btn_start = 1'b0;
      step(10); chk("resume_before_tick_seg1", seg_led_1, S2);
      step(1);  chk("resume_tick_seg1", seg_led_1, S1);

      // load pulse coincides with the tick that would reach 00
      step(1);
      btn_load = 1'b1;
      step(7);  chk("load_pre_running", {8'd0, running}, 9'd1);
      step(1);  chk("load_running", {8'd0, running}, 9'd0);
                chk("load_over_tick_alarm", {8'd0, alarm}, 9'd0);
      btn_load = 1'b0;
      step(1);  chk("load_seg1", seg_led_1, S3);
                chk("load_seg2", seg_led_2, S0);
      step(10);

      // short glitch is rejected
      btn_start = 1'b1;
      step(3);
      btn_start = 1'b0;
      step(12); chk("glitch_running", {8'd0, running}, 9'd0);
                chk("glitch_seg1", seg_led_1, S3);
      step(5);

      // simultaneous load and start: load wins
      btn_start = 1'b1;
      btn_load = 1'b1;
      step(8);  chk("both_running", {8'd0, running}, 9'd0);
      btn_start = 1'b0;
      btn_load = 1'b0;
      step(1);  chk("both_seg1", seg_led_1, S3);
                chk("both_running_after", {8'd0, running}, 9'd0);
      step(10);

      // reset in the middle of a run
      btn_start = 1'b1;
      step(8);  chk("rst_test_running", {8'd0, running}, 9'd1);
      btn_start = 1'b0;
      step(12); chk("rst_test_seg1_02", seg_led_1, S2);
      rst = 1'b0;
      step(1);  chk("midrst_running", {8'd0, running}, 9'd0);
                chk("midrst_alarm", {8'd0, alarm}, 9'd0);
                chk("midrst_seg1", seg_led_1, S3);
                chk("midrst_seg2", seg_led_2, S0);
      rst = 1'b1;
      step(20); chk("post_rst_running", {8'd0, running}, 9'd0);
                chk("post_rst_seg1", seg_led_1, S3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Two-digit 1 Hz countdown timer. It is the down-counting counterpart of the 0-23 up-counter display block.
- Loads a preset value and decrements to 00, driven by two debounced pushbuttons: start/pause and load.
- Drives the same two 9-bit seven-segment outputs, {2'b00, seg7}, active-high, segments a..g = bits 0..6, digit 0 = 7'h3f.
- Asserts an alarm output on reaching 00. Sits directly behind the board buttons and in front of the LED pins.

Parameters:
- TICK_DIV, 12000000, clk cycles per count tick (1 Hz at 12 MHz); range 2 or more.
- DEBOUNCE_CYCLES, 240000, consecutive stable samples required before a button level is accepted (20 ms); range 2 or more.
- START_VAL, 24, preset count loaded at reset and on load; range 1..99, decimal.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-low.
- btn_start, in, 1: raw start/pause pushbutton, active-high, asynchronous.
- btn_load, in, 1: raw load pushbutton, active-high, asynchronous.
- seg_led_1, out, 9: ones digit, {2'b00, seg7}.
- seg_led_2, out, 9: tens digit, {2'b00, seg7}.
- running, out, 1: high while in RUN.
- alarm, out, 1: high while in DONE.

Behaviour:
- Reset (rst low at a clk edge):
  - state=IDLE; tens/ones=START_VAL (tens=START_VAL/10, ones=START_VAL%10).
  - Tick counter=0; debounce state cleared (debounced levels 0).
  - running=0, alarm=0; seg outputs show START_VAL (default 24: seg_led_2=9'h05b, seg_led_1=9'h066).
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: increments while the synced level differs from the debounced level, clears when equal. When it has counted DEBOUNCE_CYCLES differing samples, the debounced level flips.
  - Rising edge of the debounced level gives a 1-cycle press pulse, exactly DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge. Release produces no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Tick generator:
  - Counts 0..TICK_DIV-1 only in RUN; tick is a 1-cycle pulse at the terminal count.
  - Cleared on every entry to RUN, so the first decrement occurs exactly TICK_DIV cycles after the press pulse.
  - Holds its value in PAUSE; RUN is resumed with a cleared counter.
- Count, BCD, two 4-bit digits:
  - On tick: if ones!=0, ones-1; else ones=9 and tens-1.
  - If the pre-decrement value is 01, the result is 00 and the state goes to DONE in the same cycle.
  - No wrap below 00.
- FSM:
  - IDLE: start -> RUN (running=1).
  - RUN: start -> PAUSE; tick at 01 -> DONE.
  - PAUSE: start -> RUN.
  - DONE: alarm=1, count frozen at 00; start -> IDLE with START_VAL reloaded.
  - Any state: load -> IDLE, START_VAL reloaded, tick counter cleared, running=0, alarm=0.
  - Simultaneous load and start pulses: load wins, start ignored.
  - Tick and start in the same cycle in RUN: the decrement is applied and the state goes to PAUSE.
- Outputs:
  - seg_led_1/2 are registered from the digits through the segment ROM, 1 cycle after a digit change.
  - running and alarm are registered with the state, no extra delay.
- Reset mid-count: the next cycle is in full reset state; no pending press or tick survives.

Optional Feature:
- Macro: COUNTDOWN_BLINK_DONE_EN.
- Defined: in DONE, both seg outputs alternate between 00 and blank (9'h000). The display changes every TICK_DIV/2 cycles, starting with 00 on DONE entry. A dedicated half-period counter runs only in DONE and is cleared on exit. alarm stays steady high.
- Undefined: DONE shows steady 00; no blink counter is synthesized.

Decomposition:
- Package timer_pkg:
  - 7-bit segment constants for digits 0-9 and blank.
  - State enum {IDLE, RUN, PAUSE, DONE}, 2 bits.
  - Function digit_to_seg(4-bit)->7-bit; values above 9 map to blank.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, key_raw, key_press), instantiated twice.

Test Plan:
(Bench parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4, START_VAL=3, unless stated.)
- Reset -> seg_led_2=9'h03f, seg_led_1=9'h04f, running=0, alarm=0.
- Clean start press -> pulse 7 cycles later; running=1; count 03->02->01->00 at 10, 20, 30 cycles after the pulse; alarm=1 at 00; seg_led_1=9'h03f.
- Start press, then second press after 15 cycles -> PAUSE at count 02, frozen. Third press -> resume; 01 exactly 10 cycles after that pulse.
- btn_start high for 3 cycles only -> no pulse, state stays IDLE. Load and start pulses in the same cycle -> IDLE, count 03, running=0.
- START_VAL=20 -> count 20->19 on first tick: seg_led_2=9'h006, seg_led_1=9'h06f.
- With COUNTDOWN_BLINK_DONE_EN -> in DONE, outputs toggle 9'h03f/9'h000 every 5 cycles. Start press -> IDLE, count 03, alarm=0. rst low during RUN -> reset values on the next cycle.
